ram_access_arbiter: RTL

RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

---
 rtl/ram_access_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one RAM write port and one read port among NUM_REQ requesters.
// Optional macro RAM_ARB_BYPASS_EN: write-first forwarding when a write and a read hit the same address.
module ram_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      ram_wr_en,
  output logic [ADDR_W-1:0]         ram_wr_addr,
  output logic [DATA_W-1:0]         ram_data_in,
  output logic                      ram_rd_en,
  output logic [ADDR_W-1:0]         ram_rd_addr,
  input  logic [DATA_W-1:0]         ram_data_out
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [NUM_REQ-1:0] wr_elig, rd_elig;
  logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic [DATA_W-1:0]  rd_src;
  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  // Grants are masked by rst_n so nothing is offered while reset is held.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
      assign wr_elig[gi]   = rst_n & req_valid[gi] & req_we[gi];
      assign rd_elig[gi]   = rst_n & req_valid[gi] & ~req_we[gi];
    end
  endgenerate

  // First eligible index at or above ptr, wrapping past NUM_REQ-1.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                                 input logic [PTR_W-1:0]   ptr);
    logic [NUM_REQ-1:0] gnt;
    logic               found;
    logic [PTR_W:0]     idx_w;
    gnt   = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx_w = {1'b0, ptr} + (PTR_W+1)'(off);
      if (idx_w >= NUM_REQ_W) idx_w = idx_w - NUM_REQ_W;
      if (!found && elig[idx_w[PTR_W-1:0]]) begin
        gnt[idx_w[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return gnt;
  endfunction

  always_comb begin
    wr_gnt = rr_pick(wr_elig, wr_ptr_reg);
    rd_gnt = rr_pick(rd_elig, rd_ptr_reg);
  end

  always_comb begin
    ram_wr_addr = '0;
    ram_data_in = '0;
    ram_rd_addr = '0;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_gnt[i]) begin
        ram_wr_addr = ram_wr_addr | addr_arr[i];
        ram_data_in = ram_data_in | wdata_arr[i];
        wr_ptr_next = PTR_W'((i + 1) % NUM_REQ);
      end
      if (rd_gnt[i]) begin
        ram_rd_addr = ram_rd_addr | addr_arr[i];
        rd_ptr_next = PTR_W'((i + 1) % NUM_REQ);
      end
    end
  end

  assign req_ready = wr_gnt | rd_gnt;
  assign ram_wr_en = |wr_gnt;
  assign ram_rd_en = |rd_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      rsp_valid_reg <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      rsp_valid_reg <= rd_gnt;
    end
  end

`ifdef RAM_ARB_BYPASS_EN
  logic              byp_hit_reg;
  logic [DATA_W-1:0] byp_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_hit_reg  <= 1'b0;
      byp_data_reg <= '0;
    end else begin
      byp_hit_reg  <= ram_wr_en & ram_rd_en & (ram_wr_addr == ram_rd_addr);
      byp_data_reg <= ram_data_in;
    end
  end

  assign rd_src = byp_hit_reg ? byp_data_reg : ram_data_out;
`else
  assign rd_src = ram_data_out;
`endif

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = (|rsp_valid_reg) ? rd_src : '0;

endmodule
